// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and record types for the register-file write arbiter.
// Default widths here match the integer register file of the core.
package regfile_write_arbiter_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 5;
    localparam int REG_ZERO      = 0;

    // One register-file write: destination and data.
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rw;
        logic [DATA_WIDTH-1:0]    busw;
    } reg_wr_t;

endpackage

// File: rtl/regfile_write_arbiter_sync_fifo.sv
// Small synchronous FIFO with occupancy count.
// Push on full and pop on empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: storage is not reset; only pointers and count define validity,
    // so clearing the array would add reset fan-out for no functional gain.
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback and a buffered
// long-latency result stream; tracks outstanding destinations for hazards.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH    = regfile_write_arbiter_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = regfile_write_arbiter_pkg::ADDRESS_WIDTH,
    parameter int FIFO_DEPTH    = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          WbRegWr,
    input  logic [ADDRESS_WIDTH-1:0]      WbRW,
    input  logic [DATA_WIDTH-1:0]         WbBusW,
    input  logic                          LlValid,
    input  logic [ADDRESS_WIDTH-1:0]      LlRW,
    input  logic [DATA_WIDTH-1:0]         LlBusW,
    output logic                          LlReady,
    input  logic                          IssueValid,
    input  logic [ADDRESS_WIDTH-1:0]      IssueRW,
    input  logic [ADDRESS_WIDTH-1:0]      RA,
    input  logic [ADDRESS_WIDTH-1:0]      RB,
    output logic                          BusyA,
    output logic                          BusyB,
    output logic                          PipeStall,
    output logic                          RegWr,
    output logic [ADDRESS_WIDTH-1:0]      RW,
    output logic [DATA_WIDTH-1:0]         BusW,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

    import regfile_write_arbiter_pkg::REG_ZERO;

    localparam int REC_W = ADDRESS_WIDTH + DATA_WIDTH;
    localparam int NREG  = 2 ** ADDRESS_WIDTH;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_RW = ADDRESS_WIDTH'(REG_ZERO);

    logic                     w_wb_go;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [REC_W-1:0]         w_head;
    logic [ADDRESS_WIDTH-1:0] w_head_rw;
    logic [DATA_WIDTH-1:0]    w_head_busw;
    logic [NREG-1:0]          w_busy_nxt;
    logic [NREG-1:0]          r_busy;
    logic [STV_W-1:0]         r_starve;

    assign w_wb_go = WbRegWr && (WbRW != ZERO_RW);

    // Ready looks only at registered occupancy, never at this cycle's pop.
    assign LlReady = !w_fifo_full && !Rst;

    // Results aimed at the zero register are accepted and dropped.
    assign w_push = LlValid && LlReady && (LlRW != ZERO_RW);
    assign w_pop  = !Rst && !w_wb_go && !w_fifo_empty;

    assign {w_head_rw, w_head_busw} = w_head;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_push  (w_push),
        .i_wdata ({LlRW, LlBusW}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (FifoCount),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        RegWr = 1'b0;
        RW    = WbRW;
        BusW  = WbBusW;
        if (!Rst) begin
            if (w_wb_go) begin
                RegWr = 1'b1;
            end else if (!w_fifo_empty) begin
                RegWr = 1'b1;
                RW    = w_head_rw;
                BusW  = w_head_busw;
            end
        end
    end

    // Counts writeback-blocked cycles while results wait in the buffer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_starve <= '0;
        end else if (w_pop || w_fifo_empty) begin
            r_starve <= '0;
        end else if (w_wb_go && (r_starve != STV_W'(STARVE_LIMIT))) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    assign PipeStall = !Rst && (r_starve == STV_W'(STARVE_LIMIT));

    // Clear applied before set, so an issue to the draining register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_rw] = 1'b0;
        end
        if (IssueValid && (IssueRW != ZERO_RW)) begin
            w_busy_nxt[IssueRW] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign BusyA = !Rst && r_busy[RA];
    assign BusyB = !Rst && r_busy[RB];

endmodule
